// File: rtl/thread_dispatch_rsp_pkg.sv
// Shared message codes, bus widths, thread-table entry and FSM encoding for
// the thread dispatcher responder.
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package thread_dispatch_rsp_pkg;

   localparam logic [`CPU_MSG_SIZE-1:0] CPU_R_FORK_THRD = `CPU_MSG_SIZE'(1);
   localparam logic [`CPU_MSG_SIZE-1:0] CPU_R_STOP_THRD = `CPU_MSG_SIZE'(2);
   localparam logic [`CPU_MSG_SIZE-1:0] CPU_R_FORK_DONE = `CPU_MSG_SIZE'(3);
   localparam logic [`CPU_MSG_SIZE-1:0] CPU_R_STOP_DONE = `CPU_MSG_SIZE'(4);

   typedef struct packed {
      logic                  valid;
      logic [`ADDR_SIZE-1:0] addr;
      logic [`DATA_SIZE-1:0] data;
   } thrd_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FORK_ALLOC,
      ST_STOP_SCAN,
      ST_RESP,
      ST_SCHED_SCAN
   } state_t;

endpackage

// File: rtl/thread_dispatch_rsp_thread_table.sv
// DEPTH-entry thread register file: one write port, one clear port, one
// indexed read port and a lowest-free-slot priority encoder with full flag.
module thread_table
   import thread_dispatch_rsp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  thrd_entry_t      wr_entry,
   input  logic             clr,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] rd_idx,
   output thrd_entry_t      rd_entry,
   output logic [IDX_W-1:0] free_idx,
   output logic             full
);

   thrd_entry_t tbl_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else begin
         if (we)  tbl_q[wr_idx]        <= wr_entry;
         if (clr) tbl_q[clr_idx].valid <= 1'b0;
      end
   end

   assign rd_entry = tbl_q[rd_idx];

   // Walk from the top down so the lowest free index is the last one written.
   always_comb begin
      free_idx = '0;
      full     = 1'b1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!tbl_q[i].valid) begin
            free_idx = i[IDX_W-1:0];
            full     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/thread_dispatch_rsp.sv
// Dispatcher-side responder: serves FORK/STOP thread requests against a live
// thread table and a round-robin next-thread lookup for the scheduler.
// Optional THRD_STOP_MISS_EN adds a sticky stop_miss output.
module thread_dispatch_rsp
   import thread_dispatch_rsp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_msg_pulse,
   input  logic [`CPU_MSG_SIZE-1:0] cpu_msg_in,
   input  logic [`ADDR_SIZE-1:0]    addr_in,
   input  logic [`DATA_SIZE-1:0]    data_in,
   output logic [`CPU_MSG_SIZE-1:0] cpu_msg_out,
   output logic                     disp_online,
   input  logic                     sched_req,
   output logic                     sched_ack,
   output logic [`ADDR_SIZE-1:0]    cur_addr,
   output logic [`DATA_SIZE-1:0]    cur_data,
   output logic                     cur_valid,
   output logic [IDX_W:0]           thrd_count,
   output logic                     fork_ovf,
`ifdef THRD_STOP_MISS_EN
   output logic                     stop_miss,
`endif
   output logic                     req_ovr
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t                   state_q, state_d;
   logic [`ADDR_SIZE-1:0]    lat_addr_q;
   logic [`DATA_SIZE-1:0]    lat_data_q;
   logic [IDX_W-1:0]         idx_q;
   logic [IDX_W-1:0]         scan_cnt_q;
   logic [IDX_W-1:0]         rr_ptr_q;
   logic [IDX_W:0]           count_q;
   logic [`CPU_MSG_SIZE-1:0] msg_q;
   logic                     ack_q;
   logic [`ADDR_SIZE-1:0]    cur_addr_q;
   logic [`DATA_SIZE-1:0]    cur_data_q;
   logic                     cur_valid_q;
   logic                     fork_ovf_q;
   logic                     req_ovr_q;

   logic                     valid_req;
   logic                     is_fork;
   logic                     tbl_we, tbl_clr, tbl_full;
   logic [IDX_W-1:0]         free_idx;
   thrd_entry_t              rd_entry, wr_entry;
   logic                     stop_hit;
   logic                     sched_last;

   assign is_fork    = (cpu_msg_in == CPU_R_FORK_THRD);
   assign valid_req  = cpu_msg_pulse && (is_fork || cpu_msg_in == CPU_R_STOP_THRD);
   assign stop_hit   = rd_entry.valid && (rd_entry.addr == lat_addr_q);
   assign sched_last = (scan_cnt_q == LAST_IDX);
   assign wr_entry   = '{valid: 1'b1, addr: lat_addr_q, data: lat_data_q};

   // Both scans share the single read port; idx_q is seeded on scan entry.
   thread_table #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
      .clk      (clk),
      .rst      (rst),
      .we       (tbl_we),
      .wr_idx   (free_idx),
      .wr_entry (wr_entry),
      .clr      (tbl_clr),
      .clr_idx  (idx_q),
      .rd_idx   (idx_q),
      .rd_entry (rd_entry),
      .free_idx (free_idx),
      .full     (tbl_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tbl_we  = 1'b0;
      tbl_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid_req)      state_d = is_fork ? ST_FORK_ALLOC : ST_STOP_SCAN;
            else if (sched_req) state_d = ST_SCHED_SCAN;
         end
         ST_FORK_ALLOC: begin
            tbl_we  = !tbl_full;
            state_d = ST_RESP;
         end
         ST_STOP_SCAN: begin
            if (stop_hit) begin
               tbl_clr = 1'b1;
               state_d = ST_RESP;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP:       state_d = ST_IDLE;
         ST_SCHED_SCAN: if (rd_entry.valid || sched_last) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_addr_q  <= '0;
         lat_data_q  <= '0;
         idx_q       <= '0;
         scan_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         count_q     <= '0;
         msg_q       <= '0;
         ack_q       <= 1'b0;
         cur_addr_q  <= '0;
         cur_data_q  <= '0;
         cur_valid_q <= 1'b0;
         fork_ovf_q  <= 1'b0;
         req_ovr_q   <= 1'b0;
      end else begin
         msg_q <= '0;
         ack_q <= 1'b0;
         if (valid_req && state_q != ST_IDLE) req_ovr_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (valid_req) begin
                  lat_addr_q <= addr_in;
                  lat_data_q <= data_in;
                  idx_q      <= '0;
               end else if (sched_req) begin
                  idx_q      <= rr_ptr_q + 1'b1;
                  scan_cnt_q <= '0;
               end
            end
            ST_FORK_ALLOC: begin
               if (tbl_full) fork_ovf_q <= 1'b1;
               else          count_q    <= count_q + 1'b1;
               msg_q <= CPU_R_FORK_DONE;
            end
            ST_STOP_SCAN: begin
               if (stop_hit) begin
                  count_q <= count_q - 1'b1;
                  if (idx_q == rr_ptr_q) cur_valid_q <= 1'b0;
                  msg_q <= CPU_R_STOP_DONE;
               end else if (idx_q == LAST_IDX) begin
                  msg_q <= CPU_R_STOP_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_SCHED_SCAN: begin
               if (rd_entry.valid) begin
                  rr_ptr_q    <= idx_q;
                  cur_addr_q  <= rd_entry.addr;
                  cur_data_q  <= rd_entry.data;
                  cur_valid_q <= 1'b1;
                  ack_q       <= 1'b1;
               end else if (sched_last) begin
                  cur_valid_q <= 1'b0;
                  ack_q       <= 1'b1;
               end else begin
                  idx_q      <= idx_q + 1'b1;
                  scan_cnt_q <= scan_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef THRD_STOP_MISS_EN
   logic stop_miss_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stop_miss_q <= 1'b0;
      else if (state_q == ST_STOP_SCAN && !stop_hit && idx_q == LAST_IDX)
         stop_miss_q <= 1'b1;
   end

   assign stop_miss = stop_miss_q;
`endif

   assign cpu_msg_out = msg_q;
   assign disp_online = (state_q == ST_IDLE);
   assign sched_ack   = ack_q;
   assign cur_addr    = cur_addr_q;
   assign cur_data    = cur_data_q;
   assign cur_valid   = cur_valid_q;
   assign thrd_count  = count_q;
   assign fork_ovf    = fork_ovf_q;
   assign req_ovr     = req_ovr_q;

endmodule

// File: tb/tb_thread_dispatch_rsp.sv
// Directed self-checking bench for thread_dispatch_rsp.
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_thread_dispatch_rsp;

   localparam logic [3:0] C_FORK      = 4'd1;
   localparam logic [3:0] C_STOP      = 4'd2;
   localparam logic [3:0] C_FORK_DONE = 4'd3;
   localparam logic [3:0] C_STOP_DONE = 4'd4;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     cpu_msg_pulse = 1'b0;
   logic [`CPU_MSG_SIZE-1:0] cpu_msg_in = '0;
   logic [`ADDR_SIZE-1:0]    addr_in = '0;
   logic [`DATA_SIZE-1:0]    data_in = '0;
   logic [`CPU_MSG_SIZE-1:0] cpu_msg_out;
   logic                     disp_online;
   logic                     sched_req = 1'b0;
   logic                     sched_ack;
   logic [`ADDR_SIZE-1:0]    cur_addr;
   logic [`DATA_SIZE-1:0]    cur_data;
   logic                     cur_valid;
   logic [3:0]               thrd_count;
   logic                     fork_ovf;
   logic                     req_ovr;
`ifdef THRD_STOP_MISS_EN
   logic                     stop_miss;
`endif

   int total = 0;
   int bad   = 0;

   thread_dispatch_rsp #(.DEPTH(8), .IDX_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_msg_pulse (cpu_msg_pulse),
      .cpu_msg_in    (cpu_msg_in),
      .addr_in       (addr_in),
      .data_in       (data_in),
      .cpu_msg_out   (cpu_msg_out),
      .disp_online   (disp_online),
      .sched_req     (sched_req),
      .sched_ack     (sched_ack),
      .cur_addr      (cur_addr),
      .cur_data      (cur_data),
      .cur_valid     (cur_valid),
      .thrd_count    (thrd_count),
      .fork_ovf      (fork_ovf),
`ifdef THRD_STOP_MISS_EN
      .stop_miss     (stop_miss),
`endif
      .req_ovr       (req_ovr)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cpu_msg_pulse = 1'b0;
      sched_req = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   // Presents one request pulse; returns one cycle after the sampling edge.
   task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d);
      cpu_msg_pulse = 1'b1;
      cpu_msg_in    = code;
      addr_in       = a;
      data_in       = d;
      cyc();
      cpu_msg_pulse = 1'b0;
      cpu_msg_in    = '0;
   endtask

   // n0 = cycles already elapsed since the pulse-sampling edge.
   task automatic wait_done(input int n0, input logic [3:0] code, input int lat, input string nm);
      int n;
      n = n0;
      while (cpu_msg_out == 0 && n < 20) begin
         cyc();
         n++;
      end
      total++;
      if (cpu_msg_out !== code) begin
         bad++;
         $display("FAIL %s code got=%0h exp=%0h", nm, cpu_msg_out, code);
      end
      total++;
      if (n != lat) begin
         bad++;
         $display("FAIL %s latency got=%0d exp=%0d", nm, n, lat);
      end
      cyc();
      total++;
      if (cpu_msg_out !== 4'd0 || disp_online !== 1'b1) begin
         bad++;
         $display("FAIL %s idle-after got msg=%0h online=%0b exp 0/1", nm, cpu_msg_out, disp_online);
      end
   endtask

   task automatic fork_thrd(input logic [31:0] a, input string nm);
      send(C_FORK, a, a + 32'd1);
      wait_done(1, C_FORK_DONE, 2, nm);
   endtask

   task automatic check_count(input logic [3:0] exp, input string nm);
      total++;
      if (thrd_count !== exp) begin
         bad++;
         $display("FAIL %s count got=%0d exp=%0d", nm, thrd_count, exp);
      end
   endtask

   task automatic wait_ack(output int cycles);
      cyc();
      cycles = 1;
      while (sched_ack !== 1'b1 && cycles < 30) begin
         cyc();
         cycles++;
      end
      total++;
      if (sched_ack !== 1'b1) begin
         bad++;
         $display("FAIL sched_ack timeout got=%0b exp=1", sched_ack);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc();
      total++;
      if (cpu_msg_out !== 4'd0 || sched_ack !== 1'b0 || cur_valid !== 1'b0 ||
          thrd_count !== 4'd0 || fork_ovf !== 1'b0 || req_ovr !== 1'b0 || cur_addr !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs msg=%0h ack=%0b cv=%0b cnt=%0d ovf=%0b ovr=%0b exp all 0",
                  cpu_msg_out, sched_ack, cur_valid, thrd_count, fork_ovf, req_ovr);
      end
      rst = 1'b1;
      cyc();
      total++;
      if (disp_online !== 1'b1) begin
         bad++;
         $display("FAIL reset_online got=%0b exp=1", disp_online);
      end
      // Unknown code must be ignored entirely.
      send(4'd7, 32'h123, 32'h0);
      total++;
      if (disp_online !== 1'b1 || req_ovr !== 1'b0) begin
         bad++;
         $display("FAIL ignore_code online=%0b ovr=%0b exp 1/0", disp_online, req_ovr);
      end
   endtask

   task automatic test_fork();
      do_reset();
      send(C_FORK, 32'h100, 32'h200);
      total++;
      if (disp_online !== 1'b0 || cpu_msg_out !== 4'd0) begin
         bad++;
         $display("FAIL fork_cyc1 online=%0b msg=%0h exp 0/0", disp_online, cpu_msg_out);
      end
      cyc();
      total++;
      if (disp_online !== 1'b0 || cpu_msg_out !== C_FORK_DONE) begin
         bad++;
         $display("FAIL fork_cyc2 online=%0b msg=%0h exp 0/3", disp_online, cpu_msg_out);
      end
      cyc();
      total++;
      if (disp_online !== 1'b1 || cpu_msg_out !== 4'd0) begin
         bad++;
         $display("FAIL fork_cyc3 online=%0b msg=%0h exp 1/0", disp_online, cpu_msg_out);
      end
      check_count(4'd1, "fork_count");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) fork_thrd(32'h100 * (i + 1), "ovf_fill");
      check_count(4'd8, "ovf_full_count");
      total++;
      if (fork_ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_early got=%0b exp=0", fork_ovf);
      end
      fork_thrd(32'h900, "ovf_ninth");
      total++;
      if (fork_ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_flag got=%0b exp=1", fork_ovf);
      end
      check_count(4'd8, "ovf_count");
      // 0x900 must not be in the table: its STOP scans to the end.
      send(C_STOP, 32'h900, 32'h0);
      wait_done(1, C_STOP_DONE, 9, "ovf_not_stored");
      check_count(4'd8, "ovf_count_after_stop");
   endtask

   task automatic test_stop();
      do_reset();
      fork_thrd(32'h100, "stop_f0");
      fork_thrd(32'h140, "stop_f1");
      fork_thrd(32'h180, "stop_f2");
      send(C_STOP, 32'h180, 32'hdead);
      wait_done(1, C_STOP_DONE, 4, "stop_hit");
      check_count(4'd2, "stop_count");
`ifdef THRD_STOP_MISS_EN
      total++;
      if (stop_miss !== 1'b0) begin
         bad++;
         $display("FAIL stop_miss_early got=%0b exp=0", stop_miss);
      end
`endif
      send(C_STOP, 32'h555, 32'h0);
      wait_done(1, C_STOP_DONE, 9, "stop_miss_lat");
      check_count(4'd2, "stop_miss_count");
`ifdef THRD_STOP_MISS_EN
      total++;
      if (stop_miss !== 1'b1) begin
         bad++;
         $display("FAIL stop_miss_flag got=%0b exp=1", stop_miss);
      end
`endif
   endtask

   task automatic test_sched();
      int cy;
      do_reset();
      for (int i = 0; i < 6; i++) fork_thrd(32'h1000 + 32'h10 * i, "sched_fill");
      send(C_STOP, 32'h1010, 32'h0);
      wait_done(1, C_STOP_DONE, 3, "sched_stop1");
      send(C_STOP, 32'h1030, 32'h0);
      wait_done(1, C_STOP_DONE, 5, "sched_stop3");
      send(C_STOP, 32'h1040, 32'h0);
      wait_done(1, C_STOP_DONE, 6, "sched_stop4");
      check_count(4'd3, "sched_count");
      sched_req = 1'b1;
      wait_ack(cy);
      total++;
      if (cur_addr !== 32'h1020 || cur_data !== 32'h1021 || cur_valid !== 1'b1 || cy != 3) begin
         bad++;
         $display("FAIL sched_first addr=%0h data=%0h cv=%0b cyc=%0d exp 1020/1021/1/3",
                  cur_addr, cur_data, cur_valid, cy);
      end
      wait_ack(cy);
      total++;
      if (cur_addr !== 32'h1050 || cur_valid !== 1'b1) begin
         bad++;
         $display("FAIL sched_second addr=%0h cv=%0b exp 1050/1", cur_addr, cur_valid);
      end
      wait_ack(cy);
      sched_req = 1'b0;
      total++;
      if (cur_addr !== 32'h1000 || cur_valid !== 1'b1) begin
         bad++;
         $display("FAIL sched_wrap addr=%0h cv=%0b exp 1000/1", cur_addr, cur_valid);
      end
      cyc();
      send(C_STOP, 32'h1000, 32'h0);
      wait_done(1, C_STOP_DONE, 2, "sched_stop_cur");
      total++;
      if (cur_valid !== 1'b0) begin
         bad++;
         $display("FAIL sched_cur_cleared got=%0b exp=0", cur_valid);
      end
      send(C_STOP, 32'h1020, 32'h0);
      wait_done(1, C_STOP_DONE, 4, "sched_stop2");
      send(C_STOP, 32'h1050, 32'h0);
      wait_done(1, C_STOP_DONE, 7, "sched_stop5");
      check_count(4'd0, "sched_empty_count");
      sched_req = 1'b1;
      wait_ack(cy);
      sched_req = 1'b0;
      total++;
      if (cur_valid !== 1'b0 || cy != 9) begin
         bad++;
         $display("FAIL sched_empty cv=%0b cyc=%0d exp 0/9", cur_valid, cy);
      end
      cyc();
   endtask

   task automatic test_overrun();
      do_reset();
      fork_thrd(32'h100, "ovr_f0");
      fork_thrd(32'h140, "ovr_f1");
      fork_thrd(32'h180, "ovr_f2");
      send(C_STOP, 32'h180, 32'h0);
      send(C_FORK, 32'h999, 32'h0);
      total++;
      if (req_ovr !== 1'b1) begin
         bad++;
         $display("FAIL ovr_flag got=%0b exp=1", req_ovr);
      end
      wait_done(2, C_STOP_DONE, 4, "ovr_stop_completes");
      check_count(4'd2, "ovr_count");
   endtask

   task automatic test_reset_mid_scan();
      int seen;
      send(C_STOP, 32'h555, 32'h0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      total++;
      if (cpu_msg_out !== 4'd0 || thrd_count !== 4'd0 || req_ovr !== 1'b0 || disp_online !== 1'b1) begin
         bad++;
         $display("FAIL midrst_outputs msg=%0h cnt=%0d ovr=%0b online=%0b exp 0/0/0/1",
                  cpu_msg_out, thrd_count, req_ovr, disp_online);
      end
      cyc();
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (cpu_msg_out !== 4'd0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL midrst_no_done got=%0d exp=0", seen);
      end
      // Previously live 0x100 is gone: STOP misses.
      send(C_STOP, 32'h100, 32'h0);
      wait_done(1, C_STOP_DONE, 9, "midrst_table_empty");
      check_count(4'd0, "midrst_count");
   endtask

   initial begin
      test_reset();
      test_fork();
      test_overflow();
      test_stop();
      test_sched();
      test_overrun();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/thread_dispatch_rsp.md
Name: thread_dispatch_rsp

Overview:
- Dispatcher-side responder for the inter-CPU thread protocol; the per-core thread controller is the initiator.
- Accepts CPU_R_FORK_THRD / CPU_R_STOP_THRD requests (msg + addr + data, qualified by cpu_msg_pulse) and maintains a table of live threads.
- Answers each request with CPU_R_FORK_DONE / CPU_R_STOP_DONE.
- Also serves a round-robin "next thread" lookup for the scheduler.

Parameters:
- DEPTH, 8, number of thread-table entries.
- IDX_W, 3, index width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_msg_pulse  in  1  request strobe from initiator, one cycle.
- cpu_msg_in  in  `CPU_MSG_SIZE  request code.
- addr_in  in  `ADDR_SIZE  thread header address.
- data_in  in  `DATA_SIZE  thread data base (0 = none).
- cpu_msg_out  out  `CPU_MSG_SIZE  response code; 0 when idle.
- disp_online  out  1  high only when idle and able to accept a request.
- sched_req  in  1  level request for next thread.
- sched_ack  out  1  one-cycle completion of sched_req.
- cur_addr  out  `ADDR_SIZE  selected thread addr.
- cur_data  out  `DATA_SIZE  selected thread data.
- cur_valid  out  1  cur_* refer to a live entry.
- thrd_count  out  IDX_W+1  live entries.
- fork_ovf  out  1  sticky: FORK received while table full.
- req_ovr  out  1  sticky: pulse with valid code received while not IDLE.

Behaviour:
- Reset (async, rst=0):
  - state IDLE; all outputs 0 except disp_online=1 once rst releases.
  - Table valid bits, rr_ptr, count and sticky flags are cleared.
  - A reset mid-operation aborts the operation with no DONE emitted.
- Request latch: in IDLE, when cpu_msg_pulse=1 and cpu_msg_in is FORK or STOP, latch code/addr_in/data_in.
  - FORK goes to FORK_ALLOC; STOP goes to STOP_SCAN (idx=0).
  - Any other code is ignored and state stays IDLE.
  - A valid pulse seen outside IDLE is dropped and sets req_ovr.
- FORK_ALLOC (one cycle):
  - Lowest-index free slot, by priority encoder, gets {addr, data, valid=1}; count++.
  - Table full: nothing is stored and fork_ovf is set.
  - Either way, go to RESP with FORK_DONE.
- STOP_SCAN (one entry per cycle):
  - On valid && addr==latched addr: clear valid, count--, and if idx==rr_ptr clear cur_valid; go to RESP with STOP_DONE.
  - At idx==DEPTH-1 with no match: go to RESP with STOP_DONE (miss).
  - data_in is not compared.
- RESP: cpu_msg_out = DONE code for exactly one cycle, then IDLE with cpu_msg_out=0.
- Latency:
  - FORK: DONE is visible in the 2nd cycle after the pulse-sampling edge.
  - STOP: DONE appears after match index + 2 cycles, at most DEPTH+1 cycles.
- disp_online = (state==IDLE).
- SCHED_SCAN:
  - Entered from IDLE when sched_req=1 and no valid pulse is present. A request has priority on the same edge.
  - Scan starts at rr_ptr+1 mod DEPTH and checks one entry per cycle, up to DEPTH entries, so it wraps and may return the same entry.
  - First valid entry: rr_ptr←idx, cur_*←entry, cur_valid=1.
  - None found: cur_valid=0 and rr_ptr is unchanged.
  - sched_ack pulses for one cycle on exit; then IDLE.
- Width rules:
  - count saturates neither way, because the invariants guarantee 0..DEPTH.
  - Index arithmetic wraps modulo DEPTH.

Optional Feature:
- Macro THRD_STOP_MISS_EN.
- When defined: extra output stop_miss (1 bit, sticky), set when a STOP scan ends without a match. Cleared only by reset.
- When undefined: the port is absent and a miss is silently acknowledged with STOP_DONE.

Decomposition:
- Shared package/include holds:
  - message codes CPU_R_FORK_THRD, CPU_R_STOP_THRD, CPU_R_FORK_DONE, CPU_R_STOP_DONE;
  - `CPU_MSG_SIZE, `ADDR_SIZE, `DATA_SIZE;
  - a typedef for a thread-table entry {valid, addr, data};
  - the state encoding.
- One natural sub-module, thread_table: DEPTH-entry register file with a write port, clear port, read-by-index, and a lowest-free priority encoder / full flag. The FSM stays in the top.

Test Plan:
- Reset then FORK addr=0x100 data=0x200 → FORK_DONE 2 cycles after pulse; thrd_count=1; disp_online low for exactly 2 cycles.
- 8 FORKs, then a 9th with addr=0x900 → 9th still gets FORK_DONE; fork_ovf=1; count=8; 0x900 not stored.
- FORK 0x100/0x140/0x180, then STOP 0x180 → STOP_DONE 4 cycles after pulse; count=2.
- STOP 0x555 on a table without it → STOP_DONE after DEPTH+1 cycles; count unchanged; stop_miss=1 when THRD_STOP_MISS_EN is defined.
- Entries at idx 0, 2, 5; sched_req held → successive acks yield 2, 5, 0; STOP of the current entry clears cur_valid; empty table → cur_valid=0.
- Pulse during STOP_SCAN → req_ovr=1 and the ongoing STOP completes normally. Assert rst mid-scan → no DONE; outputs 0; table empty.
